// File: rtl/cnm_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cnm_arb
//  Purpose  : Round-robin arbiter that lets two requesters share one external
//             complex multiplier. In IDLE it grants one pending requester,
//             loads that requester's operands into the mul_* registers, waits
//             MUL_LAT cycles, captures the product and holds it until the
//             granted requester takes it.
//  Ports    :
//    clk, reset                 clock / asynchronous active-high reset
//    in_valid0/1, in_ready0/1   operand handshake, one pair per requester
//    rea/ima/req/imq 0/1        8-bit signed operands a=rea+j*ima, q=req+j*imq
//    out_valid0/1, out_ready0/1 result handshake, one pair per requester
//    rep_o, imp_o               16-bit signed result shared by both requesters
//    mul_rea/ima/req/imq        registered operands to the external multiplier
//    mul_rep, mul_imp           product returned by the external multiplier
//    busy                       high whenever the arbiter is not in IDLE
//  Revision : 1.0  initial release
// ============================================================================
module cnm_arb #(
   parameter int MUL_LAT = 1   // legal range 1..4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid0,
   input  logic               in_valid1,
   output logic               in_ready0,
   output logic               in_ready1,
   input  logic signed [7:0]  rea0,
   input  logic signed [7:0]  ima0,
   input  logic signed [7:0]  req0,
   input  logic signed [7:0]  imq0,
   input  logic signed [7:0]  rea1,
   input  logic signed [7:0]  ima1,
   input  logic signed [7:0]  req1,
   input  logic signed [7:0]  imq1,
   output logic               out_valid0,
   output logic               out_valid1,
   input  logic               out_ready0,
   input  logic               out_ready1,
   output logic signed [15:0] rep_o,
   output logic signed [15:0] imp_o,
   output logic signed [7:0]  mul_rea,
   output logic signed [7:0]  mul_ima,
   output logic signed [7:0]  mul_req,
   output logic signed [7:0]  mul_imq,
   input  logic signed [15:0] mul_rep,
   input  logic signed [15:0] mul_imp,
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [2:0] C_LAT = 3'(MUL_LAT);

   state_t     state_q;
   logic       last_gnt_q;
   logic [2:0] cnt_q;

   logic       w_any;
   logic       w_sel;   // 0 = requester 0, 1 = requester 1
   logic       w_idle;
   logic       w_take;  // granted requester consumes its result

   // When both requesters are pending, favour the one not served last.
   assign w_any  = in_valid0 | in_valid1;
   assign w_sel  = (in_valid0 && in_valid1) ? ~last_gnt_q : in_valid1;
   assign w_idle = (state_q == S_IDLE) && !reset;

   assign in_ready0 = w_idle && w_any && !w_sel;
   assign in_ready1 = w_idle && w_any &&  w_sel;

   // Only the granted requester's out_ready matters; the other is ignored
   // because its out_valid is never set.
   assign w_take = (out_valid0 && out_ready0) || (out_valid1 && out_ready1);

   assign busy = (state_q != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         last_gnt_q <= 1'b1;   // so requester 0 wins the first contested grant
         cnt_q      <= 3'd0;
         mul_rea    <= 8'sd0;
         mul_ima    <= 8'sd0;
         mul_req    <= 8'sd0;
         mul_imq    <= 8'sd0;
         rep_o      <= 16'sd0;
         imp_o      <= 16'sd0;
         out_valid0 <= 1'b0;
         out_valid1 <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid0 && in_ready0) begin
                  mul_rea    <= rea0;
                  mul_ima    <= ima0;
                  mul_req    <= req0;
                  mul_imq    <= imq0;
                  last_gnt_q <= 1'b0;
                  cnt_q      <= C_LAT;
                  state_q    <= S_WAIT;
               end else if (in_valid1 && in_ready1) begin
                  mul_rea    <= rea1;
                  mul_ima    <= ima1;
                  mul_req    <= req1;
                  mul_imq    <= imq1;
                  last_gnt_q <= 1'b1;
                  cnt_q      <= C_LAT;
                  state_q    <= S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  // Product is passed through untouched, no rounding.
                  rep_o      <= mul_rep;
                  imp_o      <= mul_imp;
                  out_valid0 <= ~last_gnt_q;
                  out_valid1 <=  last_gnt_q;
                  state_q    <= S_RESP;
               end
            end
            S_RESP: begin
               if (w_take) begin
                  out_valid0 <= 1'b0;
                  out_valid1 <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cnm_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnm_arb
//  Purpose  : Self-checking bench for cnm_arb. Two instances (MUL_LAT=1 and
//             MUL_LAT=3) share all inputs; each is compared every cycle
//             against a transaction-level reference model that tracks which
//             requester holds the multiplier and the edge at which its
//             result becomes due. The external multiplier is modelled
//             combinationally from the registered operands.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cnm_arb;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic v0, v1, ordy0, ordy1;
   logic signed [7:0] rea0, ima0, req0, imq0, rea1, ima1, req1, imq1;

   logic              ir0 [2];
   logic              ir1 [2];
   logic              ov0 [2];
   logic              ov1 [2];
   logic              bsy [2];
   logic signed [15:0] rep [2];
   logic signed [15:0] imp [2];
   logic signed [7:0]  mra [2];
   logic signed [7:0]  mia [2];
   logic signed [7:0]  mrq [2];
   logic signed [7:0]  miq [2];
   logic signed [15:0] mrep[2];
   logic signed [15:0] mimp[2];

   function automatic logic signed [15:0] cre(input logic signed [7:0] a, b, c, d);
      int t;
      t = int'(a) * int'(c) - int'(b) * int'(d);
      return t[15:0];
   endfunction

   function automatic logic signed [15:0] cim(input logic signed [7:0] a, b, c, d);
      int t;
      t = int'(a) * int'(d) + int'(b) * int'(c);
      return t[15:0];
   endfunction

   assign mrep[0] = cre(mra[0], mia[0], mrq[0], miq[0]);
   assign mimp[0] = cim(mra[0], mia[0], mrq[0], miq[0]);
   assign mrep[1] = cre(mra[1], mia[1], mrq[1], miq[1]);
   assign mimp[1] = cim(mra[1], mia[1], mrq[1], miq[1]);

   cnm_arb #(.MUL_LAT(1)) u_dut0 (
      .clk(clk), .reset(rst),
      .in_valid0(v0), .in_valid1(v1), .in_ready0(ir0[0]), .in_ready1(ir1[0]),
      .rea0(rea0), .ima0(ima0), .req0(req0), .imq0(imq0),
      .rea1(rea1), .ima1(ima1), .req1(req1), .imq1(imq1),
      .out_valid0(ov0[0]), .out_valid1(ov1[0]),
      .out_ready0(ordy0), .out_ready1(ordy1),
      .rep_o(rep[0]), .imp_o(imp[0]),
      .mul_rea(mra[0]), .mul_ima(mia[0]), .mul_req(mrq[0]), .mul_imq(miq[0]),
      .mul_rep(mrep[0]), .mul_imp(mimp[0]), .busy(bsy[0])
   );

   cnm_arb #(.MUL_LAT(3)) u_dut1 (
      .clk(clk), .reset(rst),
      .in_valid0(v0), .in_valid1(v1), .in_ready0(ir0[1]), .in_ready1(ir1[1]),
      .rea0(rea0), .ima0(ima0), .req0(req0), .imq0(imq0),
      .rea1(rea1), .ima1(ima1), .req1(req1), .imq1(imq1),
      .out_valid0(ov0[1]), .out_valid1(ov1[1]),
      .out_ready0(ordy0), .out_ready1(ordy1),
      .rep_o(rep[1]), .imp_o(imp[1]),
      .mul_rea(mra[1]), .mul_ima(mia[1]), .mul_req(mrq[1]), .mul_imq(miq[1]),
      .mul_rep(mrep[1]), .mul_imp(mimp[1]), .busy(bsy[1])
   );

   // ---------------- reference model ----------------
   int  lat [2] = '{1, 3};
   int  e;                    // number of rising edges seen
   bit  m_busy [2];
   bit  m_who  [2];
   bit  m_last [2];
   int  m_acc  [2];           // edge at which the operands were accepted
   logic signed [7:0]  m_op  [2][4];
   logic signed [15:0] m_pre [2];
   logic signed [15:0] m_pim [2];
   logic signed [15:0] m_sre [2];   // last result shown after a handshake
   logic signed [15:0] m_sim [2];

   int n_checks = 0;
   int n_fail   = 0;
   int log0[$];
   int log1[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 0;
         m_who[k]  = 0;
         m_last[k] = 1;
         m_acc[k]  = 0;
         for (int i = 0; i < 4; i++) m_op[k][i] = 8'sd0;
         m_pre[k] = 16'sd0; m_pim[k] = 16'sd0;
         m_sre[k] = 16'sd0; m_sim[k] = 16'sd0;
      end
   endtask

   function automatic bit is_resp(input int k);
      return m_busy[k] && (e >= m_acc[k] + lat[k]);
   endfunction

   function automatic bit grant_sel(input int k);
      return (v0 && v1) ? !m_last[k] : v1;
   endfunction

   task automatic check_all();
      bit idle, resp, any, sel;
      logic signed [15:0] er, ei;
      for (int k = 0; k < 2; k++) begin
         idle = !m_busy[k];
         resp = is_resp(k);
         any  = v0 | v1;
         sel  = grant_sel(k);
         er   = resp ? m_pre[k] : m_sre[k];
         ei   = resp ? m_pim[k] : m_sim[k];
         chk($sformatf("in_ready0[%0d]", k),  ir0[k], !rst && idle && any && !sel);
         chk($sformatf("in_ready1[%0d]", k),  ir1[k], !rst && idle && any &&  sel);
         chk($sformatf("out_valid0[%0d]", k), ov0[k], resp && !m_who[k]);
         chk($sformatf("out_valid1[%0d]", k), ov1[k], resp &&  m_who[k]);
         chk($sformatf("busy[%0d]", k),       bsy[k], m_busy[k]);
         chk($sformatf("rep_o[%0d]", k),      rep[k], er);
         chk($sformatf("imp_o[%0d]", k),      imp[k], ei);
         chk($sformatf("mul_rea[%0d]", k),    mra[k], m_op[k][0]);
         chk($sformatf("mul_ima[%0d]", k),    mia[k], m_op[k][1]);
         chk($sformatf("mul_req[%0d]", k),    mrq[k], m_op[k][2]);
         chk($sformatf("mul_imq[%0d]", k),    miq[k], m_op[k][3]);
      end
   endtask

   task automatic model_step();
      bit sel;
      if (rst) return;
      for (int k = 0; k < 2; k++) begin
         sel = grant_sel(k);
         if (!m_busy[k] && (v0 || v1)) begin
            m_busy[k] = 1;
            m_who[k]  = sel;
            m_last[k] = sel;
            m_acc[k]  = e + 1;
            m_op[k][0] = sel ? rea1 : rea0;
            m_op[k][1] = sel ? ima1 : ima0;
            m_op[k][2] = sel ? req1 : req0;
            m_op[k][3] = sel ? imq1 : imq0;
            m_pre[k] = cre(m_op[k][0], m_op[k][1], m_op[k][2], m_op[k][3]);
            m_pim[k] = cim(m_op[k][0], m_op[k][1], m_op[k][2], m_op[k][3]);
         end else if (is_resp(k) && (m_who[k] ? ordy1 : ordy0)) begin
            m_busy[k] = 0;
            m_sre[k]  = m_pre[k];
            m_sim[k]  = m_pim[k];
         end
      end
   endtask

   // One clock cycle: inputs were set at the falling edge by the caller.
   task automatic tick();
      if (rst) model_reset();
      #1;
      check_all();
      if (ir0[0] && v0) log0.push_back(0);
      if (ir1[0] && v1) log0.push_back(1);
      if (ir0[1] && v0) log1.push_back(0);
      if (ir1[1] && v1) log1.push_back(1);
      model_step();
      @(posedge clk);
      e++;
      @(negedge clk);
   endtask

   task automatic set_ops0(input int a, b, c, d);
      rea0 = 8'(a); ima0 = 8'(b); req0 = 8'(c); imq0 = 8'(d);
   endtask

   task automatic set_ops1(input int a, b, c, d);
      rea1 = 8'(a); ima1 = 8'(b); req1 = 8'(c); imq1 = 8'(d);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      e = 0;
      rst = 1'b1;
      v0 = 0; v1 = 0; ordy0 = 0; ordy1 = 0;
      set_ops0(0, 0, 0, 0);
      set_ops1(0, 0, 0, 0);
      model_reset();
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;

      // Single op: a=3+4j, q=2-1j on requester 0.
      set_ops0(3, 4, 2, -1);
      v0 = 1; ordy0 = 1;
      tick();                 // acceptance edge
      v0 = 0;
      tick();                 // MUL_LAT=1 instance captures on this edge
      chk("single_ov0",  ov0[0], 1'b1);
      chk("single_rep",  rep[0], 16'sd10);
      chk("single_imp",  imp[0], 16'sd5);
      tick();                 // handshake
      chk("single_idle", bsy[0], 1'b0);
      repeat (4) tick();

      // Both requesters valid continuously: alternating grants.
      do_reset();
      log0.delete();
      set_ops0(2, 3, -1, 5);
      set_ops1(1, 1, 1, 1);
      v0 = 1; v1 = 1; ordy0 = 1; ordy1 = 1;
      for (int i = 0; i < 12; i++) begin
         if (ov1[0]) begin
            chk("rr_rep1", rep[0], 16'sd0);
            chk("rr_imp1", imp[0], 16'sd2);
         end
         tick();
      end
      chk("rr_count", (log0.size() >= 4), 1'b1);
      if (log0.size() >= 4) begin
         chk("rr_g0", log0[0], 0);
         chk("rr_g1", log0[1], 1);
         chk("rr_g2", log0[2], 0);
         chk("rr_g3", log0[3], 1);
      end
      v0 = 0; v1 = 0;
      repeat (8) tick();

      // Backpressure on requester 0 while requester 1 waits.
      do_reset();
      set_ops0(-7, 12, 33, -90);
      set_ops1(5, -6, 7, -8);
      v0 = 1; ordy0 = 0; ordy1 = 0;
      tick();
      v0 = 0; v1 = 1;
      repeat (7) tick();
      ordy0 = 1;
      tick();                 // handshake for both instances
      chk("bp_next_grant1", ir1[0], 1'b1);
      ordy0 = 0; ordy1 = 1;
      tick();
      v1 = 0;
      repeat (8) tick();

      // MUL_LAT=3 with a=q=-128.
      do_reset();
      set_ops0(-128, 0, -128, 0);
      v0 = 1; ordy0 = 0;
      tick();
      v0 = 0;
      chk("lat3_busy_acc", bsy[1], 1'b1);
      tick();
      tick();
      chk("lat3_ov_early", ov0[1], 1'b0);
      tick();
      chk("lat3_ov",   ov0[1], 1'b1);
      chk("lat3_rep",  rep[1], 16'sd16384);
      chk("lat3_imp",  imp[1], 16'sd0);
      chk("lat3_busy", bsy[1], 1'b1);
      ordy0 = 1;
      tick();
      chk("lat3_done", bsy[1], 1'b0);
      repeat (3) tick();

      // Reset in WAIT discards the transaction.
      ordy0 = 1; ordy1 = 1;
      set_ops0(9, 9, 9, 9);
      v0 = 1;
      tick();
      v0 = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (5) tick();
      log0.delete();
      log1.delete();
      v0 = 1; v1 = 1;
      tick();
      chk("rst_first0_i0", (log0.size() > 0) ? log0[0] : 99, 0);
      chk("rst_first0_i1", (log1.size() > 0) ? log1[0] : 99, 0);
      v0 = 0; v1 = 0;
      repeat (6) tick();

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         v0    = ($urandom_range(0, 99) < 40);
         v1    = ($urandom_range(0, 99) < 40);
         ordy0 = ($urandom_range(0, 99) < 60);
         ordy1 = ($urandom_range(0, 99) < 60);
         set_ops0($urandom, $urandom, $urandom, $urandom);
         set_ops1($urandom, $urandom, $urandom, $urandom);
         rst   = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      v0 = 0; v1 = 0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
